// File: rtl/imem_load_ctrl.sv
//==============================================================================
// Module      : imem_load_ctrl
// Description : Shares the single instruction-memory port between the fetch
//               stage and a word-stream program loader. Optional fetch bounds
//               checking is enabled by defining IMEM_BOUNDS_CHECK_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module imem_load_ctrl #(
  parameter int                  ADDR_W  = 64,
  parameter int                  INSTR_W = 32,
  parameter int                  DEPTH   = 1024,
  parameter logic [INSTR_W-1:0]  NOP     = 32'h00000013,
  localparam int                 AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  // fetch side
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic [INSTR_W-1:0] instr,
  output logic               cpu_stall,
  output logic               cpu_restart,
  output logic               fetch_fault,
  // loader side
  input  logic               ld_start,
  input  logic               ld_valid,
  input  logic               ld_last,
  input  logic [INSTR_W-1:0] ld_data,
  output logic               ld_ready,
  output logic               ld_done,
  output logic               ld_ovf,
  // memory port
  output logic [AW-1:0]      mem_addr,
  output logic               mem_we,
  output logic [INSTR_W-1:0] mem_wdata,
  input  logic [INSTR_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_LOAD  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [AW-1:0] c_last_word = AW'(DEPTH - 1);

  state_t          r_state;
  logic [AW-1:0]   r_wcnt;
  logic            r_ready;
  logic            r_done;
  logic            r_restart;
  logic            r_ovf;

  logic            w_accept;
  logic            w_full;
  logic            w_in_run;
  logic            w_oob;
  logic [AW-1:0]   w_fetch_idx;

  assign w_in_run    = (r_state == S_RUN);
  assign w_accept    = ld_valid & r_ready;
  assign w_full      = (r_wcnt == c_last_word);
  assign w_fetch_idx = fetch_addr[2 +: AW];

  //--------------------------------------------------------------------------
  // Fetch bounds handling
  //--------------------------------------------------------------------------
`ifdef IMEM_BOUNDS_CHECK_EN
  // DEPTH is a power of two, so any set bit above the index field is >= DEPTH.
  assign w_oob = |fetch_addr[ADDR_W-1:2+AW];

  logic [1:0] w_unused_addr_bits;
  assign w_unused_addr_bits = fetch_addr[1:0];
`else
  assign w_oob = 1'b0;

  logic [ADDR_W-AW-1:0] w_unused_addr_bits;
  assign w_unused_addr_bits = {fetch_addr[ADDR_W-1:2+AW], fetch_addr[1:0]};
`endif

  //--------------------------------------------------------------------------
  // Control FSM
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_RUN;
      r_wcnt    <= '0;
      r_ready   <= 1'b0;
      r_done    <= 1'b0;
      r_restart <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (ld_start) begin
            r_state <= S_DRAIN;
            r_wcnt  <= '0;
            r_ovf   <= 1'b0;
          end
        end

        S_DRAIN: begin
          r_state <= S_LOAD;
          r_ready <= 1'b1;
        end

        S_LOAD: begin
          if (w_accept) begin
            // Counter may roll over on the final word; it is unused outside LOAD.
            r_wcnt <= r_wcnt + AW'(1);
            if (ld_last || w_full) begin
              r_state   <= S_DONE;
              r_ready   <= 1'b0;
              r_done    <= 1'b1;
              r_restart <= 1'b1;
              if (!ld_last) begin
                r_ovf <= 1'b1;
              end
            end
          end
        end

        S_DONE: begin
          r_state   <= S_RUN;
          r_done    <= 1'b0;
          r_restart <= 1'b0;
        end

        default: begin
          r_state   <= S_RUN;
          r_ready   <= 1'b0;
          r_done    <= 1'b0;
          r_restart <= 1'b0;
        end
      endcase
    end
  end

  //--------------------------------------------------------------------------
  // Port muxing
  //--------------------------------------------------------------------------
  always_comb begin
    mem_addr    = r_wcnt;
    mem_we      = 1'b0;
    instr       = NOP;
    fetch_fault = 1'b0;
    if (w_in_run) begin
      mem_addr    = w_fetch_idx;
      fetch_fault = w_oob;
      instr       = w_oob ? NOP : mem_rdata;
    end else if (r_state == S_LOAD) begin
      mem_we = ld_valid;
    end
  end

  assign mem_wdata   = ld_data;
  assign cpu_stall   = ~w_in_run;
  assign cpu_restart = r_restart;
  assign ld_ready    = r_ready;
  assign ld_done     = r_done;
  assign ld_ovf      = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_imem_load_ctrl.sv
//==============================================================================
// Module      : tb_imem_load_ctrl
// Description : Directed bench for imem_load_ctrl with a behavioural imem.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_imem_load_ctrl;

  localparam int          ADDR_W  = 64;
  localparam int          INSTR_W = 32;
  localparam int          DEPTH   = 1024;
  localparam int          AW      = 10;
  localparam logic [31:0] NOP     = 32'h00000013;
`ifdef IMEM_BOUNDS_CHECK_EN
  localparam bit          BC      = 1'b1;
`else
  localparam bit          BC      = 1'b0;
`endif

  logic               clk;
  logic               rst_n;
  logic [ADDR_W-1:0]  fetch_addr;
  logic [INSTR_W-1:0] instr;
  logic               cpu_stall, cpu_restart, fetch_fault;
  logic               ld_start, ld_valid, ld_last;
  logic [INSTR_W-1:0] ld_data;
  logic               ld_ready, ld_done, ld_ovf;
  logic [AW-1:0]      mem_addr;
  logic               mem_we;
  logic [INSTR_W-1:0] mem_wdata;
  logic [INSTR_W-1:0] mem_rdata;

  logic [31:0] mem [DEPTH];
  int          wr_cnt;
  int          done_cnt;
  int          n_tests;
  int          n_fail;

  imem_load_ctrl #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W),
    .DEPTH  (DEPTH),
    .NOP    (NOP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_addr (fetch_addr),
    .instr      (instr),
    .cpu_stall  (cpu_stall),
    .cpu_restart(cpu_restart),
    .fetch_fault(fetch_fault),
    .ld_start   (ld_start),
    .ld_valid   (ld_valid),
    .ld_last    (ld_last),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .ld_done    (ld_done),
    .ld_ovf     (ld_ovf),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port imem: combinational read, synchronous write.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] = mem_wdata;
      wr_cnt = wr_cnt + 1;
    end
    if (ld_done) done_cnt = done_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  typedef struct {
    string       name;
    logic [63:0] addr;
    logic [31:0] exp_instr;
    logic        exp_fault;
  } fvec_t;

  fvec_t vec [8];

  int w0, d0;

  initial begin
    n_tests = 0; n_fail = 0; wr_cnt = 0; done_cnt = 0;
    rst_n = 1'b1; fetch_addr = '0;
    ld_start = 0; ld_valid = 0; ld_last = 0; ld_data = '0;

    // Preload pattern mem[i] = 0x1000_0000 + i, mem[5] = DEADBEEF.
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000_0000 + i;
    mem[5] = 32'hDEADBEEF;

    vec[0] = '{"t1_fetch_0x14",    64'h14,  32'hDEADBEEF, 1'b0};
    vec[1] = '{"low_bits_ignored", 64'h17,  32'hDEADBEEF, 1'b0};
    vec[2] = '{"fetch_0x0",        64'h0,   32'h1000_0000, 1'b0};
    vec[3] = '{"fetch_0x8",        64'h8,   32'h1000_0002, 1'b0};
    vec[4] = '{"fetch_top_word",   64'hFFC, 32'h1000_03FF, 1'b0};
    vec[5] = '{"t6_fetch_0x1000",  64'h1000, BC ? NOP : 32'h1000_0000, BC};
    vec[6] = '{"fetch_0x1008",     64'h1008, BC ? NOP : 32'h1000_0002, BC};
    vec[7] = '{"fetch_hi_bit",     64'h8000_0000_0000_0004, BC ? NOP : 32'h1000_0001, BC};

    // T1: reset values
    #1 rst_n = 1'b0;
    settle();
    check("rst_stall",   cpu_stall,   0);
    check("rst_restart", cpu_restart, 0);
    check("rst_ready",   ld_ready,    0);
    check("rst_done",    ld_done,     0);
    check("rst_ovf",     ld_ovf,      0);
    check("rst_we",      mem_we,      0);
    check("rst_fault",   fetch_fault, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Fetch pass-through / bounds table
    for (int i = 0; i < 8; i++) begin
      fetch_addr = vec[i].addr;
      settle();
      check(vec[i].name, instr, vec[i].exp_instr);
      check({vec[i].name, "_fault"}, fetch_fault, vec[i].exp_fault);
      check({vec[i].name, "_stall"}, cpu_stall, 0);
      check({vec[i].name, "_we"}, mem_we, 0);
      tick();
    end
    fetch_addr = 64'h14;

    // T2: three-word load A,B,C
    w0 = wr_cnt; d0 = done_cnt;
    ld_start = 1; tick(); ld_start = 0; settle();
    check("t2_drain_stall", cpu_stall, 1);
    check("t2_drain_ready", ld_ready, 0);
    check("t2_drain_nop",   instr, NOP);
    tick();
    check("t2_load_ready",  ld_ready, 1);
    ld_valid = 1; ld_data = 32'hAAAA_0001; settle();
    check("t2_we",    mem_we, 1);
    check("t2_addr0", mem_addr, 0);
    tick();
    ld_data = 32'hBBBB_0002; tick();
    ld_data = 32'hCCCC_0003; ld_last = 1; tick();
    ld_valid = 0; ld_last = 0;
    ld_start = 1; settle();            // dropped: request during DONE
    check("t2_done",     ld_done, 1);
    check("t2_restart",  cpu_restart, 1);
    check("t2_done_rdy", ld_ready, 0);
    check("t2_done_stl", cpu_stall, 1);
    tick(); ld_start = 0; settle();
    check("t2_run_stall",   cpu_stall, 0);
    check("t2_run_done",    ld_done, 0);
    check("t2_run_restart", cpu_restart, 0);
    check("t2_mem0", mem[0], 32'hAAAA_0001);
    check("t2_mem1", mem[1], 32'hBBBB_0002);
    check("t2_mem2", mem[2], 32'hCCCC_0003);
    check("t2_writes", wr_cnt - w0, 3);
    check("t2_done_pulses", done_cnt - d0, 1);
    check("t2_fetch_mem5", instr, 32'hDEADBEEF);
    tick();

    // T3: valid 1,0,0,1 with ld_start colliding with ld_last
    w0 = wr_cnt;
    ld_start = 1; tick(); ld_start = 0; tick();
    ld_valid = 1; ld_data = 32'h3333_0000; tick();
    ld_valid = 0; settle(); check("t3_gap1_we", mem_we, 0); tick();
    settle(); check("t3_gap2_we", mem_we, 0); tick();
    ld_valid = 1; ld_last = 1; ld_start = 1; ld_data = 32'h3333_0001; settle();
    check("t3_addr1", mem_addr, 1);
    tick();
    ld_valid = 0; ld_last = 0; ld_start = 0; settle();
    check("t3_done", ld_done, 1);
    tick(); settle();
    check("t3_run", cpu_stall, 0);
    check("t3_writes", wr_cnt - w0, 2);
    check("t3_mem0", mem[0], 32'h3333_0000);
    check("t3_mem1", mem[1], 32'h3333_0001);
    check("t3_mem2_kept", mem[2], 32'hCCCC_0003);
    tick();

    // T4: overflow, DEPTH+4 words without ld_last
    w0 = wr_cnt; d0 = done_cnt;
    ld_start = 1; tick(); ld_start = 0; tick();
    ld_valid = 1;
    for (int i = 0; i < DEPTH + 4; i++) begin
      ld_data = 32'hC000_0000 + i;
      tick();
    end
    ld_valid = 0; settle();
    check("t4_ovf", ld_ovf, 1);
    check("t4_writes", wr_cnt - w0, DEPTH);
    check("t4_done_pulses", done_cnt - d0, 1);
    check("t4_mem0", mem[0], 32'hC000_0000);
    check("t4_mem_top", mem[DEPTH-1], 32'hC000_03FF);
    check("t4_run", cpu_stall, 0);
    tick();
    check("t4_ovf_sticky", ld_ovf, 1);

    // ld_start clears ld_ovf; then T5: reset mid-LOAD after 2 words
    ld_start = 1; tick(); ld_start = 0; settle();
    check("t4_ovf_clear", ld_ovf, 0);
    tick();
    ld_valid = 1; ld_data = 32'h5555_0000; tick();
    ld_data = 32'h5555_0001; tick();
    rst_n = 0; settle();
    check("t5_stall", cpu_stall, 0);
    check("t5_ready", ld_ready, 0);
    check("t5_we",    mem_we, 0);
    check("t5_done",  ld_done, 0);
    check("t5_restart", cpu_restart, 0);
    ld_valid = 0;
    tick();
    rst_n = 1; fetch_addr = 64'h4; settle();
    check("t5_mem0", mem[0], 32'h5555_0000);
    check("t5_fetch_w1", instr, 32'h5555_0001);
    check("t5_mem2_kept", mem[2], 32'hC000_0002);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
